down_counter: RTL and testbench

- Synchronous, loadable down counter (timer). It is the counting-down counterpart of the team's 5-bit ripple up counter.
- Software or an FSM loads a start value. The block decrements on each enabled clock, flags terminal count, and either stops (one-shot) or reloads (auto-reload).
- All bits switch on the single clock `clk`. There are no derived clocks, unlike the ripple structure.

---
 rtl/down_counter.sv | 68 ++++++
 tb/tb_down_counter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/down_counter.sv
// down_counter: loadable one-shot/auto-reload down timer; DOWN_COUNTER_STICKY_TC_EN adds tc_sticky
module down_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             zero,
`ifdef DOWN_COUNTER_STICKY_TC_EN
  output logic             tc_sticky,
`endif
  output logic             tc
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t st, st_n;
  logic [WIDTH-1:0] rel, rel_n, q_n;
  logic tc_n;
  assign zero = q == '0;
  assign busy = st == RUN;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= IDLE;
      q <= '0;
      rel <= '0;
      tc <= 1'b0;
    end else begin
      st <= st_n;
      q <= q_n;
      rel <= rel_n;
      tc <= tc_n;
    end
  // at q == 0 the expiry step replaces the decrement, so q never wraps
  always_comb begin
    st_n = st;
    q_n = q;
    rel_n = rel;
    tc_n = 1'b0;
    if (load) begin
      q_n = load_val;
      rel_n = load_val;
      st_n = (start && load_val != '0) ? RUN : IDLE;
    end else if (st == IDLE) begin
      st_n = (start && !zero) ? RUN : IDLE;
    end else if (en) begin
      if (!zero) begin
        q_n = q - WIDTH'(1);
        tc_n = q == WIDTH'(1);
      end else begin
        q_n = auto_reload ? rel : q;
        st_n = (auto_reload && rel != '0) ? RUN : IDLE;
      end
    end
  end
`ifdef DOWN_COUNTER_STICKY_TC_EN
  logic sticky;
  assign tc_sticky = sticky;
  always_ff @(posedge clk or negedge reset)
    if (!reset) sticky <= 1'b0;
    else if (load) sticky <= 1'b0;
    else if (tc_n) sticky <= 1'b1;
`endif
endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: directed self-checking bench for down_counter
module tb_down_counter;
  logic clk = 1'b0, reset = 1'b0, load = 1'b0, start = 1'b0, en = 1'b0, auto_reload = 1'b0;
  logic [4:0] load_val = '0, q;
  logic busy, zero, tc;
  int total = 0, bad = 0;
`ifdef DOWN_COUNTER_STICKY_TC_EN
  logic tc_sticky;
`endif
  down_counter #(.WIDTH(5)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .start(start),
    .en(en), .auto_reload(auto_reload), .q(q), .busy(busy), .zero(zero),
`ifdef DOWN_COUNTER_STICKY_TC_EN
    .tc_sticky(tc_sticky),
`endif
    .tc(tc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_load(input logic [4:0] v, input logic s);
    load = 1'b1; start = s; load_val = v;
    tick();
    load = 1'b0; start = 1'b0;
  endtask
  int ntc;
  initial begin
    #2;
    chk("rst_q", q, 0); chk("rst_busy", busy, 0); chk("rst_tc", tc, 0); chk("rst_zero", zero, 1);
    tick();
    reset = 1'b1;
    // 1: asynchronous reset mid-RUN
    en = 1'b0;
    do_load(5'd7, 1'b1);
    chk("r_q7", q, 7); chk("r_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_q", q, 0); chk("ar_busy", busy, 0); chk("ar_tc", tc, 0);
    tick();
    reset = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_post_q", q, 0); chk("ar_post_tc", tc, 0); chk("ar_post_busy", busy, 0);
    end
    // 2: one-shot
    auto_reload = 1'b0; en = 1'b1;
    do_load(5'd3, 1'b1);
    chk("os_q3", q, 3); chk("os_busy", busy, 1); chk("os_tc3", tc, 0); chk("os_zero3", zero, 0);
    tick(); chk("os_q2", q, 2); chk("os_tc2", tc, 0);
    tick(); chk("os_q1", q, 1); chk("os_tc1", tc, 0);
    tick(); chk("os_q0", q, 0); chk("os_tc0", tc, 1); chk("os_zero0", zero, 1); chk("os_busy0", busy, 1);
    tick(); chk("os_end_q", q, 0); chk("os_end_busy", busy, 0); chk("os_end_tc", tc, 0);
    tick(); chk("os_hold_q", q, 0); chk("os_hold_tc", tc, 0);
    // 3: auto-reload with period 3
    auto_reload = 1'b1;
    do_load(5'd2, 1'b1);
    for (int i = 0; i < 12; i++) begin
      chk("au_q", q, 2 - (i % 3));
      chk("au_tc", tc, (i % 3 == 2) ? 1 : 0);
      chk("au_busy", busy, 1);
`ifdef DOWN_COUNTER_STICKY_TC_EN
      chk("au_sticky", tc_sticky, (i >= 2) ? 1 : 0);
`endif
      tick();
    end
    en = 1'b0;
    do_load(5'd0, 1'b0);
    chk("ld0_q", q, 0); chk("ld0_tc", tc, 0); chk("ld0_busy", busy, 0);
`ifdef DOWN_COUNTER_STICKY_TC_EN
    chk("ld0_sticky", tc_sticky, 0);
`endif
    // 4: enable gating
    auto_reload = 1'b0;
    do_load(5'd4, 1'b1);
    chk("eg_q4", q, 4);
    en = 1'b1; tick(); chk("eg_a", q, 3); chk("eg_tca", tc, 0);
    en = 1'b0; tick(); chk("eg_b", q, 3); chk("eg_tcb", tc, 0);
    en = 1'b1; tick(); chk("eg_c", q, 2); chk("eg_tcc", tc, 0);
    en = 1'b0; tick(); chk("eg_d", q, 2); chk("eg_tcd", tc, 0); chk("eg_busy", busy, 1);
    // start while running does not restart
    start = 1'b1; en = 1'b1; tick(); start = 1'b0;
    chk("rs_q", q, 1); chk("rs_busy", busy, 1);
    // 5a: load 0 with start, then start alone at q == 0
    do_load(5'd0, 1'b1);
    chk("z_busy", busy, 0); chk("z_tc", tc, 0); chk("z_q", q, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("z_busy2", busy, 0); chk("z_tc2", tc, 0);
    // 5b: load during RUN aborts to IDLE
    en = 1'b0;
    do_load(5'd5, 1'b1);
    chk("lr_q5", q, 5); chk("lr_busy5", busy, 1);
    do_load(5'd9, 1'b0);
    chk("lr_q9", q, 9); chk("lr_busy9", busy, 0);
    en = 1'b1; tick();
    chk("lr_idle_q", q, 9);
    // 5c: full-scale count from 31
    do_load(5'd31, 1'b1);
    chk("fs_q31", q, 31);
    ntc = 0;
    for (int i = 0; i < 31; i++) begin
      tick();
      if (tc) ntc++;
    end
    chk("fs_q0", q, 0); chk("fs_tc", tc, 1); chk("fs_ntc", ntc, 1);
    tick(); chk("fs_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end
endmodule
